// File: rtl/maze_pkg.sv
// Shared types and constants for the maze path-finder pipeline.
package maze_pkg;

    localparam int unsigned CoordW = 10;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCalib = 3'd1,
        StTrack = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } state_e;

    localparam logic [3:0] DirUp    = 4'b0001;
    localparam logic [3:0] DirRight = 4'b0010;
    localparam logic [3:0] DirDown  = 4'b0100;
    localparam logic [3:0] DirLeft  = 4'b1000;

endpackage

// File: rtl/video_timing_counter.sv
// Video timing front end: valid edge detection, pixel/line counters, line-buffer strobes.
module video_timing_counter
    import maze_pkg::*;
#(
    parameter logic [CoordW-1:0] H_MAX = 10'd1023,
    parameter logic [CoordW-1:0] V_MAX = 10'd1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_valid,
    input  logic              line_valid,
    input  logic              data_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic [CoordW-1:0] cnt_h,
    output logic [CoordW-1:0] cnt_v,
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic              fifo_sclr
);

    logic              frame_q;
    logic              line_q;
    logic              primed_q;
    logic              line_end;
    logic [CoordW-1:0] cnt_h_q;
    logic [CoordW-1:0] cnt_v_q;

    assign line_end    = line_q & ~line_valid;
    assign frame_end   = frame_q & ~frame_valid;
    assign frame_start = ~frame_q & frame_valid;

    // frame_q resets high so a frame already in flight at reset never looks like a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q  <= 1'b1;
            line_q   <= 1'b0;
            primed_q <= 1'b0;
            cnt_h_q  <= '0;
            cnt_v_q  <= '0;
        end else begin
            frame_q <= frame_valid;
            line_q  <= line_valid;
            if (!frame_valid) begin
                primed_q <= 1'b0;
                cnt_h_q  <= '0;
                cnt_v_q  <= '0;
            end else if (line_end) begin
                primed_q <= 1'b1;
                cnt_h_q  <= '0;
                if (cnt_v_q != V_MAX) cnt_v_q <= cnt_v_q + 10'd1;
            end else if (data_valid && (cnt_h_q != H_MAX)) begin
                cnt_h_q <= cnt_h_q + 10'd1;
            end
        end
    end

    assign cnt_h      = cnt_h_q;
    assign cnt_v      = cnt_v_q;
    assign fifo_sclr  = ~frame_valid;
    assign fifo_wrreq = data_valid & frame_valid;
    assign fifo_rdreq = data_valid & primed_q;

endmodule

// File: rtl/maze_frame_sequencer.sv
// Frame-level controller: video timing plus the calibrate/track/done/lost state machine.
module maze_frame_sequencer
    import maze_pkg::*;
#(
    parameter logic [CoordW-1:0] H_MAX         = 10'd1023,
    parameter logic [CoordW-1:0] V_MAX         = 10'd1023,
    parameter logic [7:0]        CALIB_TIMEOUT = 8'd30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_frame_valid,
    input  logic              video_line_valid,
    input  logic              video_data_valid,
    input  logic              calib_ok,
    input  logic              agent_hit,
    input  logic              path_clear,
    input  logic              goal_hit,
    input  logic              restart,
    output logic [CoordW-1:0] cnt_h,
    output logic [CoordW-1:0] cnt_v,
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic              fifo_sclr,
    output logic              calib_en,
    output logic              step_en,
    output logic [2:0]        state,
    output logic [CoordW-1:0] frame_cnt,
    output logic              lost
);

    logic              frame_start;
    logic              frame_end;
    state_e            state_q, state_d;
    logic [CoordW-1:0] frame_cnt_q, frame_cnt_d;
    logic              pend_lost_q, pend_lost_d;
    logic              pend_done_q, pend_done_d;
    logic              lost_q, lost_d;
    logic              step_q, step_d;
    logic              calib_en_q;

    video_timing_counter #(
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (video_frame_valid),
        .line_valid  (video_line_valid),
        .data_valid  (video_data_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .cnt_h       (cnt_h),
        .cnt_v       (cnt_v),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_rdreq  (fifo_rdreq),
        .fifo_sclr   (fifo_sclr)
    );

    always_comb begin
        state_d     = state_q;
        pend_lost_d = pend_lost_q;
        pend_done_d = pend_done_q;
        lost_d      = lost_q;
        step_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            StIdle:  if (frame_start) state_d = StCalib;
            StCalib: begin
                if (frame_end) begin
                    if (calib_ok) begin
                        state_d = StTrack;
                    end else if (frame_cnt_q + 10'd1 == {2'b00, CALIB_TIMEOUT}) begin
                        state_d = StFault;
                    end
                end
            end
            StTrack: begin
                if (agent_hit) begin
                    if (!path_clear) begin
                        lost_d      = 1'b1;
                        pend_lost_d = 1'b1;
                    end else if (goal_hit) begin
                        pend_done_d = 1'b1;
                    end
                end
                // A hit on the frame_end cycle still counts for this frame.
                if (frame_end) begin
                    if (pend_done_d)      state_d = StDone;
                    else if (pend_lost_d) state_d = StCalib;
                    else                  step_d  = 1'b1;
                end
            end
            StDone, StFault: ;
            default: state_d = StIdle;
        endcase

        if (restart) begin
            state_d = StIdle;
            step_d  = 1'b0;
        end

        if (restart || (state_d != state_q)) begin
            pend_lost_d = 1'b0;
            pend_done_d = 1'b0;
            frame_cnt_d = '0;
        end else if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
        end

        if ((state_d == StTrack) && (state_q != StTrack)) lost_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            pend_lost_q <= 1'b0;
            pend_done_q <= 1'b0;
            lost_q      <= 1'b0;
            step_q      <= 1'b0;
            calib_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pend_lost_q <= pend_lost_d;
            pend_done_q <= pend_done_d;
            lost_q      <= lost_d;
            step_q      <= step_d;
            calib_en_q  <= (state_d == StCalib);
        end
    end

    assign state     = state_q;
    assign frame_cnt = frame_cnt_q;
    assign lost      = lost_q;
    assign step_en   = step_q;
    assign calib_en  = calib_en_q;

endmodule

// File: tb/tb_maze_frame_sequencer.sv
// Directed bench for maze_frame_sequencer: timing counters, FIFO strobes and FSM flow.
module tb_maze_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fv, lv, dv;
    logic       calib_ok, agent_hit, path_clear, goal_hit, restart;
    logic [9:0] cnt_h, cnt_v, frame_cnt;
    logic       fifo_wrreq, fifo_rdreq, fifo_sclr;
    logic       calib_en, step_en, lost;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    int base;
    bit ab;

    always #5 clk = ~clk;

    always @(posedge clk) if (step_en) step_cnt <= step_cnt + 1;

    maze_frame_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .video_frame_valid (fv),
        .video_line_valid  (lv),
        .video_data_valid  (dv),
        .calib_ok          (calib_ok),
        .agent_hit         (agent_hit),
        .path_clear        (path_clear),
        .goal_hit          (goal_hit),
        .restart           (restart),
        .cnt_h             (cnt_h),
        .cnt_v             (cnt_v),
        .fifo_wrreq        (fifo_wrreq),
        .fifo_rdreq        (fifo_rdreq),
        .fifo_sclr         (fifo_sclr),
        .calib_en          (calib_en),
        .step_en           (step_en),
        .state             (state),
        .frame_cnt         (frame_cnt),
        .lost              (lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic gap(input int n);
        fv = 1'b0;
        lv = 1'b0;
        dv = 1'b0;
        repeat (n) tick();
    endtask

    // One frame: a start cycle, nl lines of np pixels with a 2-cycle line gap, then frame end.
    // Agent hit lands on line 0, pixel 1. A reset is asserted in place of pixel (rl, rp).
    task automatic run_frame(input int nl, input int np, input bit chk, input bit hit,
                             input bit pc, input bit gh, input bit cok,
                             input int rl, input int rp, output bit aborted);
        aborted = 1'b0;
        fv = 1'b1;
        lv = 1'b0;
        dv = 1'b0;
        tick();
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                if (l == rl && p == rp) begin
                    check("mid_cnt_h", int'(cnt_h), rp);
                    check("mid_cnt_v", int'(cnt_v), rl);
                    check("mid_state", int'(state), 2);
                    reset = 1'b1;
                    #1;
                    aborted = 1'b1;
                    return;
                end
                lv = 1'b1;
                dv = 1'b1;
                agent_hit  = hit && (l == 0) && (p == 1);
                path_clear = pc;
                goal_hit   = gh;
                #1;
                if (chk) begin
                    check("fifo_rdreq", int'(fifo_rdreq), (l > 0) ? 1 : 0);
                    if (p == np - 1) begin
                        check("cnt_h_last", int'(cnt_h), p);
                        check("cnt_v_line", int'(cnt_v), l);
                        check("fifo_wrreq", int'(fifo_wrreq), 1);
                        check("fifo_sclr_in", int'(fifo_sclr), 0);
                    end
                end
                tick();
            end
            lv = 1'b0;
            dv = 1'b0;
            agent_hit = 1'b0;
            tick();
            if (chk) check("cnt_h_clear", int'(cnt_h), 0);
            tick();
        end
        calib_ok = cok;
        fv = 1'b0;
        tick();
        calib_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        fv = 1'b0; lv = 1'b0; dv = 1'b0;
        calib_ok = 1'b0; agent_hit = 1'b0; path_clear = 1'b0; goal_hit = 1'b0;
        restart = 1'b0;
        repeat (3) tick();
        check("rst_state", int'(state), 0);
        check("rst_cnt_h", int'(cnt_h), 0);
        check("rst_cnt_v", int'(cnt_v), 0);
        check("rst_step", int'(step_en), 0);
        check("rst_calib_en", int'(calib_en), 0);
        check("rst_lost", int'(lost), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_rdreq", int'(fifo_rdreq), 0);
        reset = 1'b0;
        tick();
        check("idle_hold", int'(state), 0);

        // Frame 1 of calibration: full 3 x 702 timing check.
        run_frame(3, 702, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, ab);
        check("calib_state", int'(state), 1);
        check("calib_en", int'(calib_en), 1);
        check("calib_fcnt1", int'(frame_cnt), 1);
        gap(2);
        check("sclr_between", int'(fifo_sclr), 1);
        check("wrreq_between", int'(fifo_wrreq), 0);
        check("cnt_v_between", int'(cnt_v), 0);

        for (int i = 2; i <= 29; i++) begin
            run_frame(2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, ab);
            gap(2);
        end
        check("calib_29_state", int'(state), 1);
        check("calib_29_fcnt", int'(frame_cnt), 29);
        run_frame(2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, ab);
        check("fault_state", int'(state), 4);
        check("fault_fcnt", int'(frame_cnt), 0);
        check("fault_calib_en", int'(calib_en), 0);
        gap(2);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_idle", int'(state), 0);

        // Calibrate on the first frame, then track.
        run_frame(2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, ab);
        check("track_state", int'(state), 2);
        check("track_lost", int'(lost), 0);
        check("track_no_step", int'(step_en), 0);
        gap(2);

        for (int i = 1; i <= 2; i++) begin
            base = step_cnt;
            run_frame(2, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, ab);
            check("step_pulse", int'(step_en), 1);
            check("step_state", int'(state), 2);
            check("step_fcnt", int'(frame_cnt), i);
            tick();
            check("step_one_cycle", int'(step_en), 0);
            gap(1);
            check("step_count", step_cnt - base, 1);
        end

        // Blocked path: lost, back to calibration, no step.
        base = step_cnt;
        run_frame(2, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, ab);
        check("lost_flag", int'(lost), 1);
        check("lost_state", int'(state), 1);
        gap(2);
        check("lost_no_step", step_cnt - base, 0);
        check("lost_sticky", int'(lost), 1);
        run_frame(2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, ab);
        check("retrack_state", int'(state), 2);
        check("retrack_lost", int'(lost), 0);
        gap(2);

        // Goal reached: DONE, no step, then hold.
        base = step_cnt;
        run_frame(2, 4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1, ab);
        check("done_state", int'(state), 3);
        gap(2);
        for (int i = 0; i < 5; i++) begin
            run_frame(2, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1, ab);
            gap(2);
        end
        check("done_hold", int'(state), 3);
        check("done_fcnt", int'(frame_cnt), 5);
        check("done_no_step", step_cnt - base, 0);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart2_idle", int'(state), 0);
        run_frame(2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, ab);
        gap(2);

        // Reset at cnt_h=300, cnt_v=10 while tracking.
        run_frame(12, 400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10, 300, ab);
        check("mrst_state", int'(state), 0);
        check("mrst_cnt_h", int'(cnt_h), 0);
        check("mrst_cnt_v", int'(cnt_v), 0);
        check("mrst_frame_cnt", int'(frame_cnt), 0);
        check("mrst_calib_en", int'(calib_en), 0);
        check("mrst_step", int'(step_en), 0);
        check("mrst_rdreq", int'(fifo_rdreq), 0);
        tick();
        reset = 1'b0;
        fv = 1'b1;
        lv = 1'b1;
        dv = 1'b1;
        repeat (5) tick();
        check("post_rst_cnt_h", int'(cnt_h), 5);
        check("post_rst_idle", int'(state), 0);
        lv = 1'b0;
        dv = 1'b0;
        repeat (2) tick();
        check("post_rst_cnt_v", int'(cnt_v), 1);
        check("post_rst_idle2", int'(state), 0);
        gap(3);
        check("post_rst_idle3", int'(state), 0);
        fv = 1'b1;
        tick();
        check("restart_calib", int'(state), 1);
        gap(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
